// File: rtl/breath_pwm_pkg.sv
// Shared constants and helpers for the breathing-LED PWM engine.
// Holds the default resolution, speed-index width and LED polarity.
package breath_pwm_pkg;

   localparam int   PWM_BITS_DEF = 8;
   localparam int   BASE_DIV_DEF = 768;
   localparam int   SPD_W        = 2;
   localparam int   SPD_MAX      = 3;
   localparam logic LED_OFF      = 1'b1;

   typedef logic [SPD_W-1:0] spd_t;

   typedef enum logic {
      RAMP_UP   = 1'b0,
      RAMP_DOWN = 1'b1
   } ramp_dir_e;

   // Carrier periods per duty step; a step can never be faster than one carrier.
   function automatic int stepDivisor(input int baseDiv, input spd_t spd);
      int div;
      div = baseDiv >> spd;
      if (div < 1) begin
         div = 1;
      end
      return div;
   endfunction

endpackage

// File: rtl/breath_pwm_key_edge.sv
// Registered rising-edge detector for a debounced key level.
// Emits a one-clock pulse; reset preloads the history so a held key is not an edge.
module key_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_lvl,
   output logic o_rise
);

   logic r_prev;
   logic r_rise;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev <= i_lvl;
         r_rise <= 1'b0;
      end else begin
         r_prev <= i_lvl;
         r_rise <= i_lvl & ~r_prev;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/breath_pwm.sv
// Breathing-LED PWM engine: linear duty ramp on a fixed carrier, key-selectable
// ramp speed, and a strobe at the end of every ramp for colour-phase rotation.
module breath_pwm
   import breath_pwm_pkg::*;
#(
   parameter int PWM_BITS = PWM_BITS_DEF,
   parameter int BASE_DIV = BASE_DIV_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_dir,
   input  logic                i_key_lvl,
   output logic                o_led_n,
   output logic                o_stt,
   output logic [SPD_W-1:0]    o_spd,
   output logic [PWM_BITS-1:0] o_duty
);

   localparam logic [PWM_BITS-1:0] MAX   = '1;
   localparam int                  PRE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

   logic [PWM_BITS-1:0] r_cnt;
   logic [PRE_W-1:0]    r_presc;
   logic [PWM_BITS-1:0] r_idx;
   spd_t                r_spd;
   logic                r_stt;
   logic                r_led_n;
   logic [PWM_BITS-1:0] r_duty;

   logic                w_key_rise;
   logic                w_wrap;
   logic [PRE_W-1:0]    w_div_m1;
   logic                w_step;
   logic [PWM_BITS-1:0] w_idx_next;
   logic [PWM_BITS-1:0] w_duty_next;
   ramp_dir_e           w_dir;

   key_edge u_key_edge (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_lvl  (i_key_lvl),
      .o_rise (w_key_rise)
   );

   // The step decision uses the divisor of the speed in force before any key edge.
   assign w_dir       = ramp_dir_e'(i_dir);
   assign w_wrap      = (r_cnt == MAX);
   assign w_div_m1    = PRE_W'(stepDivisor(BASE_DIV, r_spd) - 1);
   assign w_step      = w_wrap && (r_presc >= w_div_m1);
   assign w_idx_next  = w_step ? r_idx + 1'b1 : r_idx;
   assign w_duty_next = (w_dir == RAMP_DOWN) ? MAX - w_idx_next : w_idx_next;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_presc <= '0;
         r_idx   <= '0;
         r_spd   <= '0;
         r_stt   <= 1'b0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
         if (w_key_rise) begin
            r_presc <= '0;
         end else if (w_wrap) begin
            r_presc <= w_step ? '0 : r_presc + 1'b1;
         end
         r_idx <= w_idx_next;
         r_stt <= w_step && (r_idx == MAX);
         if (w_key_rise) begin
            r_spd <= r_spd + 1'b1;
         end
      end
   end

   // Duty only moves on the carrier wrap so a PWM period is never cut short.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_duty  <= (w_dir == RAMP_DOWN) ? MAX : '0;
         r_led_n <= LED_OFF;
      end else begin
         if (w_wrap) begin
            r_duty <= w_duty_next;
         end
         r_led_n <= (r_cnt < r_duty) ? ~LED_OFF : LED_OFF;
      end
   end

   assign o_led_n = r_led_n;
   assign o_stt   = r_stt;
   assign o_spd   = r_spd;
   assign o_duty  = r_duty;

endmodule
